// File: rtl/bsg_manycore_loader_arbiter.sv
// Shares the host loader link among num_req_p requesters: round-robin request
// arbitration with ID stamping, outstanding limits, response routing and fence.
module bsg_manycore_loader_arbiter #(
    parameter int num_req_p         = 4,
    parameter int packet_width_p    = 128,
    parameter int return_width_p    = 64,
    parameter int id_lsb_p          = 0,
    parameter int max_out_p         = 16,
    parameter int max_out_per_req_p = 8
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [num_req_p-1:0]                  req_v_i,
    input  logic [num_req_p*packet_width_p-1:0]   req_packet_i,
    output logic [num_req_p-1:0]                  req_ready_o,
    output logic [num_req_p-1:0]                  resp_v_o,
    output logic [return_width_p-1:0]             resp_packet_o,
    input  logic [num_req_p-1:0]                  resp_ready_i,
    output logic                                  link_v_o,
    output logic [packet_width_p-1:0]             link_packet_o,
    input  logic                                  link_ready_i,
    input  logic                                  link_resp_v_i,
    input  logic [return_width_p-1:0]             link_resp_packet_i,
    output logic                                  link_resp_ready_o,
    input  logic                                  fence_v_i,
    output logic                                  fence_done_o,
    output logic [$clog2(max_out_p):0]            out_count_o
);

    localparam int id_width_lp = $clog2(num_req_p);
    localparam int gcnt_w_lp   = $clog2(max_out_p) + 1;
    localparam int rcnt_w_lp   = $clog2(max_out_per_req_p) + 1;

    typedef enum logic [1:0] {ACTIVE, DRAIN, DONE, WAIT} state_e;

    state_e                    state_q, state_d;
    logic [id_width_lp-1:0]    ptr_q, ptr_d;
    logic [gcnt_w_lp-1:0]      gcnt_q, gcnt_d;
    logic [rcnt_w_lp-1:0]      rcnt_q [num_req_p];
    logic [rcnt_w_lp-1:0]      rcnt_d [num_req_p];
    logic                      slot_v_q, slot_v_d;
    logic [packet_width_p-1:0] slot_pkt_q, slot_pkt_d;

    logic                      accept_open;
    logic [num_req_p-1:0]      eligible;
    logic [num_req_p-1:0]      grant;
    logic                      grant_v;
    logic [id_width_lp-1:0]    grant_id;
    logic [id_width_lp-1:0]    resp_id;
    logic                      resp_ok;
    logic                      resp_rdy;
    logic                      resp_hs;

    always_comb begin
        accept_open = reset_n_i && (state_q == ACTIVE) && !fence_v_i
                   && (!slot_v_q || link_ready_i)
                   && (gcnt_q < gcnt_w_lp'(max_out_p));
        for (int unsigned i = 0; i < num_req_p; i++) begin
            eligible[i] = accept_open && req_v_i[i]
                       && (rcnt_q[i] < rcnt_w_lp'(max_out_per_req_p));
        end

        // Two passes implement the rotating priority: indices at/after ptr first, then the wrap.
        grant    = '0;
        grant_v  = 1'b0;
        grant_id = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (!grant_v && eligible[i] && (i >= 32'(ptr_q))) begin
                grant_v  = 1'b1;
                grant_id = id_width_lp'(i);
                grant[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (!grant_v && eligible[i]) begin
                grant_v  = 1'b1;
                grant_id = id_width_lp'(i);
                grant[i] = 1'b1;
            end
        end
        req_ready_o = grant;

        ptr_d = ptr_q;
        if (grant_v) begin
            ptr_d = (int'(grant_id) == num_req_p - 1) ? '0 : grant_id + id_width_lp'(1);
        end

        slot_v_d   = slot_v_q;
        slot_pkt_d = slot_pkt_q;
        if (slot_v_q && link_ready_i) begin
            slot_v_d = 1'b0;
        end
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (grant[i]) begin
                slot_v_d   = 1'b1;
                slot_pkt_d = req_packet_i[i*packet_width_p +: packet_width_p];
                slot_pkt_d[id_lsb_p +: id_width_lp] = id_width_lp'(i);
            end
        end

        // Unknown IDs and IDs with nothing outstanding never match, so they are dropped.
        resp_id  = link_resp_packet_i[id_lsb_p +: id_width_lp];
        resp_ok  = 1'b0;
        resp_rdy = 1'b0;
        resp_v_o = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (resp_id == id_width_lp'(i)) begin
                resp_ok     = (rcnt_q[i] != '0);
                resp_rdy    = resp_ready_i[i];
                resp_v_o[i] = reset_n_i && link_resp_v_i && (rcnt_q[i] != '0);
            end
        end
        link_resp_ready_o = reset_n_i && (resp_ok ? resp_rdy : 1'b1);
        resp_hs           = reset_n_i && link_resp_v_i && resp_ok && resp_rdy;
        resp_packet_o     = reset_n_i ? link_resp_packet_i : '0;

        gcnt_d = gcnt_q;
        if (grant_v && !resp_hs) begin
            gcnt_d = gcnt_q + gcnt_w_lp'(1);
        end else if (!grant_v && resp_hs) begin
            gcnt_d = gcnt_q - gcnt_w_lp'(1);
        end
        for (int unsigned i = 0; i < num_req_p; i++) begin
            rcnt_d[i] = rcnt_q[i];
            if (grant[i] && !(resp_hs && resp_id == id_width_lp'(i))) begin
                rcnt_d[i] = rcnt_q[i] + rcnt_w_lp'(1);
            end else if (!grant[i] && resp_hs && resp_id == id_width_lp'(i)) begin
                rcnt_d[i] = rcnt_q[i] - rcnt_w_lp'(1);
            end
        end

        state_d = state_q;
        case (state_q)
            ACTIVE:  if (fence_v_i) state_d = DRAIN;
            DRAIN:   if (!slot_v_q && gcnt_q == '0) state_d = DONE;
            DONE:    state_d = WAIT;
            WAIT:    if (!fence_v_i) state_d = ACTIVE;
            default: state_d = ACTIVE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= ACTIVE;
            ptr_q      <= '0;
            gcnt_q     <= '0;
            slot_v_q   <= 1'b0;
            slot_pkt_q <= '0;
            for (int unsigned i = 0; i < num_req_p; i++) rcnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gcnt_q     <= gcnt_d;
            slot_v_q   <= slot_v_d;
            slot_pkt_q <= slot_pkt_d;
            for (int unsigned i = 0; i < num_req_p; i++) rcnt_q[i] <= rcnt_d[i];
        end
    end

    assign link_v_o      = slot_v_q;
    assign link_packet_o = slot_pkt_q;
    assign fence_done_o  = (state_q == DONE);
    assign out_count_o   = gcnt_q;

    // A response for an idle or nonexistent requester indicates a protocol bug upstream.
    a_no_stray_resp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(link_resp_v_i && !resp_ok));

endmodule

// File: doc/bsg_manycore_loader_arbiter.md
Name: bsg_manycore_loader_arbiter

Overview:
- Shares the single host loader link between up to num_req_p host-side requesters (e.g. program loader, MMIO bridge, DMA engine).
- Round-robin arbitrates single-flit request packets onto the loader link and stamps each packet with the requester ID in its reg_id field.
- Enforces global and per-requester outstanding-request limits, and routes each returning response to its requester by that ID.
- Provides a fence operation that drains all outstanding traffic before acknowledging.

Parameters:
num_req_p, 4, number of requesters (2..8)
packet_width_p, 128, request packet width in bits
return_width_p, 64, response packet width in bits
id_lsb_p, 0, LSB of the reg_id field in both request and response packets
max_out_p, 16, global outstanding-request limit (power of two)
max_out_per_req_p, 8, per-requester outstanding limit (≤ max_out_p)
id_width_lp, clog2(num_req_p), requester-ID width (derived)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous, active-low reset
req_v_i  in  num_req_p  request valid, per requester
req_packet_i  in  num_req_p*packet_width_p  request packets
req_ready_o  out  num_req_p  request accepted when v&ready
resp_v_o  out  num_req_p  response valid, per requester
resp_packet_o  out  return_width_p  response packet, shared by all requesters
resp_ready_i  in  num_req_p  requester accepts response
link_v_o  out  1  packet to loader link valid
link_packet_o  out  packet_width_p  packet to loader link
link_ready_i  in  1  loader link accepts
link_resp_v_i  in  1  response from loader link valid
link_resp_packet_i  in  return_width_p  response packet
link_resp_ready_o  out  1  response accepted
fence_v_i  in  1  fence request (level)
fence_done_o  out  1  one-cycle pulse when fence completes
out_count_o  out  clog2(max_out_p)+1  total outstanding count

Behaviour:
- One clock. Reset is synchronous and active-low: all state clears on a clk_i edge while reset_n_i==0.
- Reset values: all outputs 0; RR pointer = 0; counters = 0; FSM = ACTIVE.
- Request path:
  - Eligible requester: req_v_i[i]=1, per-requester count < max_out_per_req_p, global count < max_out_p, FSM==ACTIVE.
  - Round-robin grant starts search at ptr. On a grant to i, ptr ← (i+1) mod num_req_p. ptr holds when nothing is granted.
  - Output is a 1-entry registered slot. Grant only when the slot is empty, or when it drains this cycle (link_ready_i & link_v_o). Throughput is 1 packet/cycle; latency is 1 cycle from accept to link_v_o.
  - req_ready_o[i]=1 only for the granted i; it is combinational from the current state and req_v_i.
  - Registered packet = req_packet_i[i] with bits [id_lsb_p +: id_width_lp] replaced by i. All other bits are unchanged.
  - Counters increment on accept into the slot, not on link send. link_v_o holds stable until link_ready_i.
- Response path:
  - id = link_resp_packet_i[id_lsb_p +: id_width_lp].
  - resp_packet_o = link_resp_packet_i (combinational pass-through); resp_v_o[id] = link_resp_v_i; other bits 0.
  - link_resp_ready_o = resp_ready_i[id].
  - On handshake, decrement the global count and count[id].
  - If id ≥ num_req_p or count[id]==0: drop the response (link_resp_ready_o=1, no resp_v_o), do not decrement, and assert an error in simulation.
- Simultaneous accept and response for the same requester: counts net unchanged.
- Fence FSM:
  - ACTIVE: fence_v_i=1 → DRAIN. Requests stop being granted from that cycle on.
  - DRAIN: when the output slot is empty and the global count == 0 → DONE.
  - DONE: fence_done_o=1 for exactly one cycle, then → WAIT.
  - WAIT: return to ACTIVE when fence_v_i=0.
  - Responses continue to drain in every state.
- out_count_o = global count (registered). It never exceeds max_out_p; per-requester counts never exceed max_out_per_req_p.

Test Plan:
- Reset: hold reset_n_i=0 for 3 cycles with all inputs active → all outputs 0; release → first grant goes to requester 0 within 1 cycle.
- Fairness: all 4 requesters stream requests, link_ready_i=1, responses returned immediately → grant order 0,1,2,3,0,… and each requester gets exactly 25 of 100 grants.
- ID stamping: requester 2 sends packet 0x…FFFF → link_packet_o low 2 bits = 2'b10, all upper bits equal to the input.
- Limits: requester 1 sends 10 requests with no responses → exactly 8 accepted, req_ready_o[1]=0 after that. Then 16 total across all requesters → every request blocked until a response returns.
- Response routing/backpressure: response with id=3 while resp_ready_i[3]=0 for 5 cycles → link_resp_ready_o=0 for those 5 cycles; on ready, resp_v_o=4'b1000 and out_count_o decrements by 1.
- Fence: 3 requests outstanding, assert fence_v_i → no new grants; after 3rd response, fence_done_o pulses once the following cycle; deassert fence_v_i → grants resume next cycle.
